// File: rtl/pool_window_reader_pkg.sv
// Shared pooling constants: window geometry, BRAM latency and reader FSM encoding.
package pool_window_reader_pkg;

  localparam int unsigned WIN_SIZE = 6;
  localparam int unsigned RD_LAT   = 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LAST  = 3'd2;
  localparam logic [2:0] S_HOLD  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

endpackage

// File: rtl/pool_window_reader.sv
// Reads consecutive 6-byte pooling windows from a single-port BRAM and
// presents each one as six parallel operands behind a valid/ready handshake.
// An accepted start is registered for one cycle before the first read, so the
// first BRAM read appears on the cycle after E1.
module pool_window_reader
  import pool_window_reader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_win,
  output logic              bram_en,
  output logic [ADDR_W-1:0] bram_addr,
  input  logic [DATA_W-1:0] bram_dout,
  output logic [DATA_W-1:0] ad0,
  output logic [DATA_W-1:0] ad1,
  output logic [DATA_W-1:0] ad2,
  output logic [DATA_W-1:0] ad3,
  output logic [DATA_W-1:0] ad4,
  output logic [DATA_W-1:0] ad5,
  output logic              win_valid,
  input  logic              win_ready,
  output logic [ADDR_W-1:0] win_idx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned CNT_W = 3;
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(WIN_SIZE - 1);

  logic [2:0]        r_state,     w_state_nxt;
  logic [CNT_W-1:0]  r_rd_cnt,    w_rd_cnt_nxt;
  logic [ADDR_W-1:0] r_run_base,  w_run_base_nxt;
  logic [ADDR_W-1:0] r_num,       w_num_nxt;
  logic [ADDR_W-1:0] r_win_idx,   w_win_idx_nxt;
  logic [ADDR_W-1:0] r_bram_addr, w_bram_addr_nxt;
  logic              r_pend,      w_pend_nxt;
  logic              r_bram_en,   w_bram_en_nxt;
  logic              r_win_valid, w_win_valid_nxt;
  logic              r_done,      w_done_nxt;
  logic              r_busy;
  logic [DATA_W-1:0] r_ad     [WIN_SIZE];
  logic [DATA_W-1:0] w_ad_nxt [WIN_SIZE];
  logic [CNT_W-1:0]  w_slot;

  // Read data returns RD_LAT cycles after its address, so it lands in an older slot.
  assign w_slot = r_rd_cnt - CNT_W'(RD_LAT);

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    w_state_nxt     = r_state;
    w_rd_cnt_nxt    = r_rd_cnt;
    w_run_base_nxt  = r_run_base;
    w_num_nxt       = r_num;
    w_win_idx_nxt   = r_win_idx;
    w_bram_addr_nxt = r_bram_addr;
    w_ad_nxt        = r_ad;
    w_pend_nxt      = 1'b0;
    w_bram_en_nxt   = 1'b0;
    w_win_valid_nxt = 1'b0;
    w_done_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_pend) begin
          if (r_num == '0) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt     = S_FETCH;
            w_rd_cnt_nxt    = '0;
            w_win_idx_nxt   = '0;
            w_bram_en_nxt   = 1'b1;
            w_bram_addr_nxt = r_run_base;
          end
        end else if (start) begin
          w_pend_nxt     = 1'b1;
          w_run_base_nxt = base_addr;
          w_num_nxt      = num_win;
        end
      end
      S_FETCH: begin
        if (r_rd_cnt >= CNT_W'(RD_LAT)) begin
          w_ad_nxt[w_slot] = bram_dout;
        end
        if (r_rd_cnt == RD_LAST) begin
          w_state_nxt = S_LAST;
        end else begin
          w_rd_cnt_nxt    = r_rd_cnt + CNT_W'(1);
          w_bram_en_nxt   = 1'b1;
          w_bram_addr_nxt = r_run_base + ADDR_W'(r_rd_cnt) + ADDR_W'(1);
        end
      end
      S_LAST: begin
        w_ad_nxt[WIN_SIZE-1] = bram_dout;
        w_state_nxt          = S_HOLD;
        w_win_valid_nxt      = 1'b1;
      end
      S_HOLD: begin
        if (win_ready) begin
          if (r_win_idx == r_num - ADDR_W'(1)) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt     = S_FETCH;
            w_win_idx_nxt   = r_win_idx + ADDR_W'(1);
            w_run_base_nxt  = r_run_base + ADDR_W'(WIN_SIZE);
            w_rd_cnt_nxt    = '0;
            w_bram_en_nxt   = 1'b1;
            w_bram_addr_nxt = r_run_base + ADDR_W'(WIN_SIZE);
          end
        end else begin
          w_win_valid_nxt = 1'b1;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_cnt    <= '0;
      r_run_base  <= '0;
      r_num       <= '0;
      r_win_idx   <= '0;
      r_bram_addr <= '0;
      r_pend      <= 1'b0;
      r_bram_en   <= 1'b0;
      r_win_valid <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_ad        <= '{default: '0};
    end else begin
      r_state     <= w_state_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_run_base  <= w_run_base_nxt;
      r_num       <= w_num_nxt;
      r_win_idx   <= w_win_idx_nxt;
      r_bram_addr <= w_bram_addr_nxt;
      r_pend      <= w_pend_nxt;
      r_bram_en   <= w_bram_en_nxt;
      r_win_valid <= w_win_valid_nxt;
      r_done      <= w_done_nxt;
      r_busy      <= (w_state_nxt != S_IDLE);
      r_ad        <= w_ad_nxt;
    end
  end

  assign bram_en   = r_bram_en;
  assign bram_addr = r_bram_addr;
  assign win_valid = r_win_valid;
  assign win_idx   = r_win_idx;
  assign busy      = r_busy;
  assign done      = r_done;
  assign ad0       = r_ad[0];
  assign ad1       = r_ad[1];
  assign ad2       = r_ad[2];
  assign ad3       = r_ad[3];
  assign ad4       = r_ad[4];
  assign ad5       = r_ad[5];

endmodule

// File: tb/tb_pool_window_reader.sv
// Bench for pool_window_reader: BRAM model plus a window/address reference
// computed directly from base_addr + 6k + j arithmetic.
module tb_pool_window_reader;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] num_win;
  logic          bram_en;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_dout;
  logic [DW-1:0] ad0, ad1, ad2, ad3, ad4, ad5;
  logic          win_valid;
  logic          win_ready;
  logic [AW-1:0] win_idx;
  logic          busy;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  logic [DW-1:0] mem [1024];

  logic [AW-1:0] obs_addr [$];
  int            obs_acyc [$];
  logic [47:0]   obs_win  [$];
  logic [AW-1:0] obs_idx  [$];
  int            obs_vcyc [$];
  int            obs_done;
  int            obs_done_cyc;
  int            obs_unstable;
  bit            obs_timeout;
  logic          obs_busy_end;

  pool_window_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_win(num_win),
    .bram_en(bram_en), .bram_addr(bram_addr), .bram_dout(bram_dout),
    .ad0(ad0), .ad1(ad1), .ad2(ad2), .ad3(ad3), .ad4(ad4), .ad5(ad5),
    .win_valid(win_valid), .win_ready(win_ready), .win_idx(win_idx),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Single-port BRAM, one cycle read latency.
  always @(posedge clk) if (bram_en) bram_dout <= mem[bram_addr];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input int k, input int j);
    return b + AW'(6 * k + j);
  endfunction

  function automatic logic [47:0] exp_win(input logic [AW-1:0] b, input int k);
    logic [47:0] w;
    w = '0;
    for (int j = 0; j < 6; j++) w[8*j +: 8] = mem[exp_addr(b, k, j)];
    return w;
  endfunction

  // Runs one pass and records what the DUT does; cycle numbers count edges after E0.
  task automatic run_pass(input logic [AW-1:0] b, input logic [AW-1:0] n, input int stall,
                          input int rs_cyc, input logic [AW-1:0] rs_base);
    int cyc; int hold; bit in_hold; logic [47:0] cur; int limit;
    obs_addr.delete(); obs_acyc.delete(); obs_win.delete(); obs_idx.delete(); obs_vcyc.delete();
    obs_done = 0; obs_done_cyc = -1; obs_unstable = 0; obs_timeout = 0;
    limit = 40 + (int'(n) + 1) * (stall + 12);
    base_addr = b; num_win = n; start = 1'b1; win_ready = (stall == 0);
    @(negedge clk);
    start = 1'b0;
    cyc = 0; hold = 0; in_hold = 0;
    forever begin
      @(negedge clk);
      cyc++;
      start = (cyc == rs_cyc);
      if (cyc == rs_cyc) begin base_addr = rs_base; num_win = n + AW'(3); end
      if (bram_en) begin obs_addr.push_back(bram_addr); obs_acyc.push_back(cyc); end
      if (win_valid) begin
        cur = {ad5, ad4, ad3, ad2, ad1, ad0};
        if (!in_hold) begin
          obs_win.push_back(cur); obs_idx.push_back(win_idx); obs_vcyc.push_back(cyc);
          in_hold = 1; hold = 0;
        end else if (cur !== obs_win[$] || win_idx !== obs_idx[$]) begin
          obs_unstable++;
        end
        hold++;
        win_ready = (hold > stall);
      end else begin
        in_hold = 0;
        win_ready = (stall == 0);
      end
      if (done === 1'b1) begin obs_done++; obs_done_cyc = cyc; end
      if (obs_done_cyc >= 0 && cyc > obs_done_cyc) break;
      if (cyc >= limit) begin obs_timeout = 1; break; end
    end
    start = 1'b0;
    obs_busy_end = busy;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; base_addr = '0; num_win = '0; win_ready = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({bram_en, bram_addr, win_valid, win_idx, busy, done, ad0, ad1, ad2, ad3, ad4, ad5} !== 72'd0) begin
      n_err++;
      $display("FAIL reset_state: got en=%b addr=%0d val=%b idx=%0d busy=%b done=%b ad0=%0d, required all 0",
               bram_en, bram_addr, win_valid, win_idx, busy, done, ad0);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    bit ok;
    for (int i = 0; i < 6; i++) mem[i] = DW'(10 * (i + 1));
    run_pass(10'd0, 10'd1, 0, 0, 10'd0);
    ok = (obs_addr.size() == 6);
    if (ok) for (int i = 0; i < 6; i++) if (obs_addr[i] !== AW'(i) || obs_acyc[i] != i + 1) ok = 0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL basic_addr: got %0d reads, first addr %0d, required 0..5 on cycles 1..6",
                                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[0] : 10'h3ff); end
    n_vec++;
    if (obs_win.size() != 1 || obs_win[0] !== 48'h3c_32_28_1e_14_0a || obs_idx[0] !== 10'd0 || obs_vcyc[0] != 8) begin
      n_err++;
      $display("FAIL basic_window: got n=%0d win=%h idx=%0d cyc=%0d, required win=3c32281e140a idx=0 cyc=8",
               obs_win.size(), (obs_win.size() > 0) ? obs_win[0] : 48'h0, (obs_idx.size() > 0) ? obs_idx[0] : 10'h3ff,
               (obs_vcyc.size() > 0) ? obs_vcyc[0] : -1);
    end
    n_vec++;
    if (obs_done != 1 || obs_done_cyc != 9 || obs_timeout) begin
      n_err++; $display("FAIL basic_done: got count=%0d cyc=%0d timeout=%0d, required count=1 cyc=9", obs_done, obs_done_cyc, obs_timeout);
    end
    n_vec++;
    if (obs_busy_end !== 1'b0) begin n_err++; $display("FAIL basic_busy_end: got %b required 0", obs_busy_end); end
  endtask

  task automatic test_backpressure;
    bit ok;
    for (int i = 0; i < 12; i++) mem[i] = DW'(i + 1);
    run_pass(10'd0, 10'd2, 5, 0, 10'd0);
    ok = (obs_addr.size() == 12);
    if (ok) for (int i = 0; i < 12; i++) if (obs_addr[i] !== AW'(i)) ok = 0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL bp_addr: got %0d reads, required addresses 0..11", obs_addr.size()); end
    n_vec++;
    if (obs_win.size() != 2 || obs_win[1] !== 48'h0c_0b_0a_09_08_07 || obs_idx[1] !== 10'd1) begin
      n_err++; $display("FAIL bp_window2: got n=%0d win=%h, required win=0c0b0a090807 idx=1",
                        obs_win.size(), (obs_win.size() > 1) ? obs_win[1] : 48'h0);
    end
    n_vec++;
    if (obs_unstable != 0) begin n_err++; $display("FAIL bp_stable: got %0d changes during HOLD, required 0", obs_unstable); end
    n_vec++;
    if (obs_vcyc.size() != 2 || obs_vcyc[1] != 21 || obs_done != 1 || obs_done_cyc != 27) begin
      n_err++; $display("FAIL bp_timing: got vcyc1=%0d done=%0d at %0d, required vcyc1=21 done=1 at 27",
                        (obs_vcyc.size() > 1) ? obs_vcyc[1] : -1, obs_done, obs_done_cyc);
    end
  endtask

  task automatic test_wrap;
    bit ok;
    for (int j = 0; j < 6; j++) mem[exp_addr(10'd1020, 0, j)] = DW'($urandom);
    run_pass(10'd1020, 10'd1, 0, 0, 10'd0);
    ok = (obs_addr.size() == 6);
    if (ok) for (int j = 0; j < 6; j++) if (obs_addr[j] !== AW'((1020 + j) % 1024)) ok = 0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wrap_addr: got %0d reads, last %0d, required 1020..1023,0,1",
                                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[$] : 10'h3ff); end
    n_vec++;
    if (obs_win.size() != 1 || obs_win[0] !== exp_win(10'd1020, 0)) begin
      n_err++; $display("FAIL wrap_window: got %h required %h", (obs_win.size() > 0) ? obs_win[0] : 48'h0, exp_win(10'd1020, 0));
    end
  endtask

  task automatic test_zero;
    run_pass(10'd37, 10'd0, 0, 0, 10'd0);
    n_vec++;
    if (obs_addr.size() != 0 || obs_win.size() != 0) begin
      n_err++; $display("FAIL zero_access: got reads=%0d windows=%0d, required 0 and 0", obs_addr.size(), obs_win.size());
    end
    n_vec++;
    if (obs_done != 1 || obs_done_cyc != 1 || obs_busy_end !== 1'b0) begin
      n_err++; $display("FAIL zero_done: got count=%0d cyc=%0d busy=%b, required count=1 cyc=1 busy=0", obs_done, obs_done_cyc, obs_busy_end);
    end
  endtask

  task automatic test_start_busy;
    bit ok;
    for (int i = 0; i < 6; i++) mem[i] = DW'($urandom);
    run_pass(10'd0, 10'd1, 0, 3, 10'd100);
    ok = (obs_addr.size() == 6);
    if (ok) for (int i = 0; i < 6; i++) if (obs_addr[i] !== AW'(i)) ok = 0;
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL busy_start_addr: got %0d reads, last %0d, required 0..5",
                                     obs_addr.size(), (obs_addr.size() > 0) ? obs_addr[$] : 10'h3ff); end
    n_vec++;
    if (obs_done != 1 || obs_win.size() != 1 || obs_win[0] !== exp_win(10'd0, 0)) begin
      n_err++; $display("FAIL busy_start_done: got done=%0d windows=%0d, required 1 and 1 matching", obs_done, obs_win.size());
    end
  endtask

  task automatic test_reset_mid;
    int cyc; int dn;
    for (int i = 0; i < 12; i++) mem[i] = DW'(i + 1);
    // Reset during FETCH at rd_cnt=3.
    base_addr = 10'd0; num_win = 10'd2; win_ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_vec++;
    if (bram_en !== 1'b1 || bram_addr !== 10'd3) begin
      n_err++; $display("FAIL rstmid_pre: got en=%b addr=%0d, required en=1 addr=3", bram_en, bram_addr);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bram_en, bram_addr, win_valid, win_idx, busy, done, ad0, ad1, ad2, ad3, ad4, ad5} !== 72'd0) begin
      n_err++; $display("FAIL rstmid_fetch: got en=%b addr=%0d busy=%b ad0=%0d, required all 0", bram_en, bram_addr, busy, ad0);
    end
    dn = 0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) dn++; end
    rst = 1'b0;
    repeat (3) begin @(negedge clk); if (done !== 1'b0) dn++; end
    n_vec++;
    if (dn != 0) begin n_err++; $display("FAIL rstmid_nodone: got %0d done cycles, required 0", dn); end
    // Reset during HOLD.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (win_valid !== 1'b1 && cyc < 30) begin @(negedge clk); cyc++; end
    n_vec++;
    if (win_valid !== 1'b1 || ad0 !== 8'd1 || ad5 !== 8'd6) begin
      n_err++; $display("FAIL rstmid_hold_pre: got valid=%b ad0=%0d ad5=%0d, required 1,1,6", win_valid, ad0, ad5);
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if ({bram_en, bram_addr, win_valid, win_idx, busy, done, ad0, ad1, ad2, ad3, ad4, ad5} !== 72'd0) begin
      n_err++; $display("FAIL rstmid_hold: got valid=%b busy=%b ad0=%0d ad5=%0d, required all 0", win_valid, busy, ad0, ad5);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_pass(10'd0, 10'd2, 0, 0, 10'd0);
    n_vec++;
    if (obs_win.size() != 2 || obs_win[0] !== exp_win(10'd0, 0) || obs_win[1] !== exp_win(10'd0, 1) ||
        obs_done != 1 || obs_done_cyc != 17) begin
      n_err++; $display("FAIL rstmid_fresh: got windows=%0d done=%0d at %0d, required 2 windows, done=1 at 17",
                        obs_win.size(), obs_done, obs_done_cyc);
    end
  endtask

  task automatic test_random;
    logic [AW-1:0] b; int n; int st; bit ok; int exp_done;
    for (int i = 0; i < 1024; i++) mem[i] = DW'($urandom);
    for (int it = 0; it < 25; it++) begin
      b  = AW'($urandom_range(0, 1023));
      n  = $urandom_range(1, 4);
      st = $urandom_range(0, 3);
      run_pass(b, AW'(n), st, 0, 10'd0);
      ok = (obs_addr.size() == 6 * n);
      if (ok) for (int k = 0; k < n; k++) for (int j = 0; j < 6; j++)
        if (obs_addr[6 * k + j] !== exp_addr(b, k, j)) ok = 0;
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rand%0d_addr: got %0d reads, required %0d from base %0d",
                                       it, obs_addr.size(), 6 * n, b); end
      ok = (obs_win.size() == n);
      if (ok) for (int k = 0; k < n; k++)
        if (obs_win[k] !== exp_win(b, k) || obs_idx[k] !== AW'(k)) ok = 0;
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rand%0d_windows: got %0d windows first %h, required %0d first %h",
                                       it, obs_win.size(), (obs_win.size() > 0) ? obs_win[0] : 48'h0, n, exp_win(b, 0)); end
      ok = (obs_vcyc.size() == n);
      if (ok) for (int k = 0; k < n; k++) if (obs_vcyc[k] != 8 + k * (st + 8)) ok = 0;
      exp_done = 8 + (n - 1) * (st + 8) + st + 1;
      n_vec++;
      if (!ok || obs_done != 1 || obs_done_cyc != exp_done || obs_unstable != 0 || obs_busy_end !== 1'b0) begin
        n_err++; $display("FAIL rand%0d_timing: got done=%0d at %0d unstable=%0d busy=%b, required done=1 at %0d stable idle",
                          it, obs_done, obs_done_cyc, obs_unstable, obs_busy_end, exp_done);
      end
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_wrap;
    test_zero;
    test_start_busy;
    test_reset_mid;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pool_window_reader.md
Name: pool_window_reader

Overview:
- Sequential front end of the pooling datapath. It reads 6-byte pooling windows out of a single-port BRAM and presents them as six parallel operands, ad0..ad5, to the averaging unit.
- On start it walks num_win consecutive windows beginning at base_addr. Window k occupies addresses base_addr+6k .. base_addr+6k+5.
- Each completed window is offered through a valid/ready handshake. When every window has been accepted, the block pulses done.

Parameters:
- ADDR_W, 10, BRAM address width; also the width of num_win and win_idx.
- DATA_W, 8, BRAM data width and operand width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a pass; sampled only in IDLE.
- base_addr  in  ADDR_W  first BRAM address of the pass; latched when start is accepted.
- num_win  in  ADDR_W  number of windows in the pass; latched when start is accepted.
- bram_en  out  1  BRAM read enable.
- bram_addr  out  ADDR_W  BRAM read address.
- bram_dout  in  DATA_W  BRAM read data; valid exactly 1 cycle after bram_en.
- ad0..ad5  out  DATA_W each  window operands; ad0 comes from the lowest address of the window.
- win_valid  out  1  ad0..ad5 hold a complete window.
- win_ready  in  1  downstream accepts the window.
- win_idx  out  ADDR_W  index of the window currently being fetched or presented.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at the end of a pass.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE. All of the following clear to 0: bram_en, bram_addr, ad0..ad5, win_valid, win_idx, busy, done, and the internal counters. Reset asserted mid-pass aborts the pass; there is no done pulse, and no partial window is retained.
- States: IDLE, FETCH, LAST, HOLD, DONE.
- IDLE:
  - start=1 with num_win>0: latch base_addr and num_win; win_idx=0, rd_cnt=0; go to FETCH.
  - start=1 with num_win=0: go to DONE. No BRAM access occurs.
- FETCH (6 cycles, rd_cnt 0..5):
  - bram_en=1; bram_addr = base_addr + 6*win_idx + rd_cnt.
  - From the second FETCH cycle onward, bram_dout is captured into the ad slot of rd_cnt-1.
  - After rd_cnt=5, go to LAST.
- LAST: bram_en=0; bram_dout is captured into ad5; go to HOLD.
- HOLD:
  - win_valid=1; ad0..ad5 and win_idx stay stable until the handshake.
  - On win_valid && win_ready: win_valid drops the next cycle.
  - If win_idx == num_win-1, go to DONE. Otherwise increment win_idx, clear rd_cnt, and go to FETCH.
- DONE: done=1 for exactly one cycle; then IDLE, where busy=0.
- Latency:
  - start is sampled at edge E0. FETCH occupies the cycles after E1..E6, LAST the cycle after E7, and win_valid is high from E8.
  - Back-to-back windows with win_ready tied high: 8 cycles per window (6 FETCH + LAST + 1 HOLD).
- Address arithmetic:
  - Computed modulo 2^ADDR_W; wrap-around is legal and silent.
  - The 6*win_idx offset is maintained as a running base incremented by 6 per window; no multiplier.
- start while busy: ignored; latched parameters are unchanged.
- Changing base_addr or num_win mid-pass has no effect.
- win_ready outside HOLD: ignored.
- ad0..ad5 retain the last window after the pass ends, until the next capture or reset.

Decomposition:
- Shared pooling package holds:
  - WIN_SIZE = 6;
  - state encoding constants for IDLE/FETCH/LAST/HOLD/DONE;
  - BRAM read latency constant RD_LAT = 1.
- No sub-module. The averaging unit is instantiated alongside this block in the parent, not inside it.

Test Plan:
- Basic pass:
  - Stimulus: BRAM[0..5] = 10,20,30,40,50,60; base_addr=0, num_win=1, win_ready=1, start pulse at E0.
  - Required: bram_addr 0..5 on consecutive cycles; win_valid high from E8 with ad0..ad5 = 10..60 and win_idx=0; done pulse 1 cycle after acceptance; busy=0 afterwards.
- Backpressure:
  - Stimulus: num_win=2, BRAM[0..11] = 1..12, win_ready held low 5 cycles in each HOLD.
  - Required: outputs stable throughout HOLD; the second window gives ad0..ad5 = 7..12 and win_idx=1; bram_addr = 6..11 for the second fetch; exactly one done.
- Wrap-around:
  - Stimulus: ADDR_W=10, base_addr=1020, num_win=1.
  - Required: bram_addr sequence is 1020,1021,1022,1023,0,1; ad values match those locations.
- Zero windows:
  - Stimulus: num_win=0, start pulse.
  - Required: bram_en never asserts; win_valid never asserts; done pulses on the cycle after the start edge.
- Start while busy:
  - Stimulus: second start pulse with base_addr=100 during FETCH of a pass at base_addr=0.
  - Required: ignored; addresses continue from 0; only one done.
- Reset mid-operation:
  - Stimulus: rst asserted during FETCH (rd_cnt=3) or during HOLD.
  - Required: all outputs 0 immediately (asynchronous) with no done; a fresh start afterwards completes correctly.
